crc_engine_scheduler: RTL and testbench

//  Round-robin scheduler that shares one bit-serial CRC encoding engine among NREQ requesters.

---
 rtl/crc_pkg.sv | 33 +++
 rtl/crc_serial_lfsr.sv | 47 ++++
 rtl/crc_engine_scheduler.sv | 179 +++++++++++++++++
 tb/tb_crc_engine_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// ---------------------------------------------------------------------------
// crc_pkg
//   Shared definitions for the CRC engine scheduler slice:
//     - state_t        : scheduler FSM states (IDLE / SHIFT / DONE)
//     - DEFAULT_*      : default requester count, data width, polynomial width
//     - CRC*_*         : standard generator polynomials, MSB = x^(M-1) term
//     - rr_next()      : round-robin pointer increment with wrap
// ---------------------------------------------------------------------------
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_NREQ = 4;
    localparam int DEFAULT_N    = 11;
    localparam int DEFAULT_M    = 5;

    // x^4 + x + 1
    localparam logic [4:0] CRC4_ITU = 5'b10011;
    // x^3 + x + 1
    localparam logic [3:0] CRC3_GSM = 4'b1011;
    // x^5 + x^2 + 1
    localparam logic [5:0] CRC5_USB = 6'b100101;

    // Index that follows idx in a ring of nreq entries.
    function automatic int rr_next(input int idx, input int nreq);
        return (idx + 1 >= nreq) ? 0 : idx + 1;
    endfunction

endpackage : crc_pkg

// File: rtl/crc_serial_lfsr.sv
// ---------------------------------------------------------------------------
// crc_serial_lfsr
//   Bit-serial CRC remainder register. Each enabled cycle folds one data bit
//   (MSB first) into the remainder, so after N enabled cycles rem holds
//   data * x^(M-1) mod poly.
// Ports
//   Clk    in   1      rising-edge clock
//   reset  in   1      asynchronous active-high reset, clears rem
//   clr    in   1      synchronous clear (start of a new word), wins over en
//   en     in   1      consume din this cycle
//   din    in   1      next data bit, MSB first
//   poly   in   M-1    generator coefficients below the implicit x^(M-1) term
//   rem    out  M-1    current remainder
// ---------------------------------------------------------------------------
module crc_serial_lfsr
    import crc_pkg::*;
#(
    parameter int M = DEFAULT_M
) (
    input  logic         Clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    input  logic [M-2:0] poly,
    output logic [M-2:0] rem
);

    logic fb;

    // The bit leaving the top of the register meets the incoming data bit;
    // when they differ the generator is subtracted (XOR) from the shifted value.
    assign fb = rem[M-2] ^ din;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            rem <= '0;
        end else if (clr) begin
            rem <= '0;
        end else if (en) begin
            rem <= {rem[M-3:0], 1'b0} ^ (fb ? poly : '0);
        end
    end

endmodule : crc_serial_lfsr

// File: rtl/crc_engine_scheduler.sv
// ---------------------------------------------------------------------------
// crc_engine_scheduler
//   Round-robin scheduler sharing one bit-serial CRC engine among NREQ
//   requesters. A granted word and the current polynomial are captured, the
//   engine runs for N cycles, and the codeword {data, remainder} is offered on
//   a valid/ready output together with the winning requester id.
// Ports
//   Clk           in   1        rising-edge clock
//   reset         in   1        asynchronous active-high reset
//   req_valid     in   NREQ     requester i has a word pending
//   req_data      in   NREQ*N   word of requester i at [i*N +: N]
//   req_ready     out  NREQ     one-hot accept, only in IDLE (combinational)
//   polynomial    in   M        generator, sampled on accept only
//   out_valid     out  1        codeword available
//   out_ready     in   1        downstream accepts codeword
//   out_codeword  out  N+M-1    {data, remainder}
//   out_id        out  IDW      requester the codeword belongs to
//   busy          out  1        high while a word is in SHIFT or DONE
// ---------------------------------------------------------------------------
module crc_engine_scheduler
    import crc_pkg::*;
#(
    parameter  int NREQ = DEFAULT_NREQ,
    parameter  int N    = DEFAULT_N,
    parameter  int M    = DEFAULT_M,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic [M-1:0]      polynomial,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N+M-2:0]    out_codeword,
    output logic [IDW-1:0]    out_id,
    output logic              busy
);

    localparam int CNT_W = $clog2(N + 1);

    state_t           state_q;
    state_t           state_d;

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant;
    logic             any_req;
    logic             accept;
    logic             shift_en;
    logic             last_bit;

    logic [N-1:0]     data_sr;
    logic [M-2:0]     poly_q;
    logic [IDW-1:0]   cur_id;
    logic [CNT_W-1:0] bit_cnt;
    logic [M-2:0]     rem;

    // The x^(M-1) coefficient is implicit in the serial divider; an illegal
    // polynomial with this bit clear is simply processed as given.
    logic             poly_msb_unused;
    assign poly_msb_unused = polynomial[M-1];

    // -----------------------------------------------------------------------
    // Round-robin arbitration: scan rr_ptr, rr_ptr+1, ... (wrapping). The scan
    // runs from the farthest offset down so the nearest requester is written
    // last and wins, which avoids an early-exit loop.
    // -----------------------------------------------------------------------
    // NOTE: every variable assigned in always_comb gets a default at the top
    // of the block so no path leaves it unassigned (no inferred latch).
    always_comb begin
        int idx;
        idx     = 0;
        grant   = '0;
        any_req = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req_valid[idx]) begin
                grant   = IDW'(idx);
                any_req = 1'b1;
            end
        end
    end

    assign req_ready = (state_q == IDLE && any_req) ? (NREQ'(1) << grant) : '0;

    // The granted requester always has valid high, so a grant in IDLE is an
    // accept at the coming edge.
    assign accept    = (state_q == IDLE) && any_req;
    assign shift_en  = (state_q == SHIFT);
    assign last_bit  = (bit_cnt == CNT_W'(N - 1));

    // -----------------------------------------------------------------------
    // FSM: state register + next-state logic
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: capture on accept, rotate the data word during SHIFT.
    // Rotating (rather than shifting out) feeds the MSB to the engine each
    // cycle and leaves the original word back in place after exactly N
    // cycles, so the same register supplies the data half of the codeword.
    // -----------------------------------------------------------------------
    // NOTE: only a handful of control/data registers exist here (no memory
    // arrays), so all of them are cleared by the asynchronous reset and an
    // interrupted word leaves no residue.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            rr_ptr  <= '0;
            data_sr <= '0;
            poly_q  <= '0;
            cur_id  <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            rr_ptr  <= IDW'(rr_next(int'(grant), NREQ));
            data_sr <= req_data[int'(grant) * N +: N];
            poly_q  <= polynomial[M-2:0];
            cur_id  <= grant;
            bit_cnt <= '0;
        end else if (shift_en) begin
            data_sr <= {data_sr[N-2:0], data_sr[N-1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    crc_serial_lfsr #(
        .M (M)
    ) u_lfsr (
        .Clk   (Clk),
        .reset (reset),
        .clr   (accept),
        .en    (shift_en),
        .din   (data_sr[N-1]),
        .poly  (poly_q),
        .rem   (rem)
    );

    // -----------------------------------------------------------------------
    // Outputs. All are decodes of registers, so they are glitch-free and hold
    // steady through a stalled DONE. The codeword is masked outside DONE so
    // partial remainders never appear on the link side.
    // -----------------------------------------------------------------------
    assign out_valid    = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign out_codeword = out_valid ? {data_sr, rem} : '0;
    assign out_id       = cur_id;

endmodule : crc_engine_scheduler

// File: tb/tb_crc_engine_scheduler.sv
// ---------------------------------------------------------------------------
// tb_crc_engine_scheduler
//   Directed bench for crc_engine_scheduler (NREQ=4, N=11, M=5, x^4+x+1).
//   Expected codewords are hand-computed remainders of data*x^4 mod x^4+x+1:
//     001 -> 3, 002 -> 6, 003 -> 5, 400 -> 9, 401 -> A, 000 -> 0.
// ---------------------------------------------------------------------------
module tb_crc_engine_scheduler;

    localparam int NREQ = 4;
    localparam int N    = 11;
    localparam int M    = 5;
    localparam int IDW  = 2;

    logic              Clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [M-1:0]      polynomial;
    logic              out_valid;
    logic              out_ready;
    logic [N+M-2:0]    out_codeword;
    logic [IDW-1:0]    out_id;
    logic              busy;

    int n_asserts = 0;
    int n_fails   = 0;

    crc_engine_scheduler #(
        .NREQ (NREQ),
        .N    (N),
        .M    (M)
    ) dut (
        .Clk          (Clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .polynomial   (polynomial),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_codeword (out_codeword),
        .out_id       (out_id),
        .busy         (busy)
    );

    always #5 Clk = ~Clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_data(input int slot, input logic [N-1:0] d);
        req_data[slot*N +: N] = d;
    endtask

    // Ticks until out_valid is seen, bounded; returns the number of edges.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            tick();
            cycles++;
        end
        if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    // Single requester word: grant, latency, codeword, id, handshake.
    task automatic run_word(input int slot, input logic [N-1:0] d,
                            input logic [N+M-2:0] exp_cw, input string tag);
        int lat;
        set_data(slot, d);
        req_valid = NREQ'(1) << slot;
        #1;
        check({tag, "_grant"}, 32'(req_ready), 32'(1) << slot);
        tick();
        req_valid = '0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_valid(lat);
        check({tag, "_latency"}, 32'(lat), 32'(N));
        check({tag, "_codeword"}, 32'(out_codeword), 32'(exp_cw));
        check({tag, "_id"}, 32'(out_id), 32'(slot));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int w;
        int lat;
        int exp_g [5];
        logic [N+M-2:0] exp_cw [NREQ];

        exp_g     = '{0, 1, 2, 3, 0};
        exp_cw[0] = 15'h0013;
        exp_cw[1] = 15'h4009;
        exp_cw[2] = 15'h0000;
        exp_cw[3] = 15'h0026;

        // ---- reset ----
        reset      = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        polynomial = 5'b10011;
        out_ready  = 1'b0;
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_codeword", 32'(out_codeword), 32'd0);
        check("rst_id", 32'(out_id), 32'd0);
        reset = 1'b0;

        // ---- 1: idle with no requests ----
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_req_ready", 32'(req_ready), 32'd0);
            check("idle_out_valid", 32'(out_valid), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end

        // ---- 2/3: single words (rr_ptr 0 -> 1 -> 2 -> 0) ----
        run_word(0, 11'h001, 15'h0013, "w001");
        run_word(1, 11'h400, 15'h4009, "w400");
        run_word(3, 11'h000, 15'h0000, "w000");

        // ---- 4: all requesting, rotation 0,1,2,3,0 ----
        set_data(0, 11'h001);
        set_data(1, 11'h400);
        set_data(2, 11'h000);
        set_data(3, 11'h002);
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            #1;
            while (req_ready == '0 && w < 40) begin
                tick();
                w++;
            end
            check("rr_grant", 32'(req_ready), 32'(1) << exp_g[k]);
            tick();
            wait_valid(lat);
            check("rr_latency", 32'(lat), 32'(N));
            check("rr_id", 32'(out_id), 32'(exp_g[k]));
            check("rr_codeword", 32'(out_codeword), 32'(exp_cw[exp_g[k]]));
        end
        req_valid = '0;
        tick();
        out_ready = 1'b0;
        check("rr_end_valid", 32'(out_valid), 32'd0);

        // ---- 5: stall in DONE, polynomial change ignored (rr_ptr = 1) ----
        set_data(1, 11'h401);
        req_valid = 4'b0010;
        #1;
        check("stall_grant", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        wait_valid(lat);
        check("stall_latency", 32'(lat), 32'(N));
        polynomial = 5'b11111;
        req_valid  = 4'hF;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_codeword", 32'(out_codeword), 32'h401A);
            check("stall_id", 32'(out_id), 32'd1);
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid  = '0;
        polynomial = 5'b10011;
        out_ready  = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall_hs_valid", 32'(out_valid), 32'd0);
        check("stall_hs_busy", 32'(busy), 32'd0);
        // Back in IDLE: the very next edge accepts (rr_ptr = 2).
        set_data(2, 11'h002);
        req_valid = 4'b0100;
        #1;
        check("next_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        check("next_accept_busy", 32'(busy), 32'd1);
        wait_valid(lat);
        check("next_codeword", 32'(out_codeword), 32'h0026);
        check("next_id", 32'(out_id), 32'd2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // ---- 6: reset after 5 SHIFT edges, then re-run (rr_ptr = 3) ----
        set_data(3, 11'h003);
        req_valid = 4'b1000;
        #1;
        check("abort_grant", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        for (int i = 0; i < 5; i++) tick();
        check("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_codeword", 32'(out_codeword), 32'd0);
        check("abort_id", 32'(out_id), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("abort_no_output", 32'(out_valid), 32'd0);
        run_word(3, 11'h003, 15'h0035, "rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule : tb_crc_engine_scheduler
